// File: rtl/layer_2_maxpool_pkg.sv
// Shared FP32 constants and helpers for the layer-2 max-pool slice.
package layer_2_maxpool_pkg;

    localparam int          FP32_WIDTH     = 32;
    localparam logic [31:0] FP32_SIGN_MASK = 32'h8000_0000;
    localparam logic [31:0] FP32_QNAN      = 32'h7FC0_0000;

    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Maps IEEE-754 ordering onto unsigned integer ordering (-0 sorts below +0).
    function automatic logic [31:0] fp32_key(input logic [31:0] x);
        return x[31] ? ~x : (x ^ FP32_SIGN_MASK);
    endfunction

    function automatic logic fp32_is_nan(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
    endfunction

endpackage

// File: rtl/layer_2_maxpool_fp32_max.sv
// Combinational FP32 maximum; on equal keys the a operand is returned.
module fp32_max
    import layer_2_maxpool_pkg::*;
(
    input  logic [FP32_WIDTH-1:0] a,
    input  logic [FP32_WIDTH-1:0] b,
    output logic [FP32_WIDTH-1:0] max_val,
    output logic                  is_nan_a,
    output logic                  is_nan_b
);

    assign max_val  = (fp32_key(b) > fp32_key(a)) ? b : a;
    assign is_nan_a = fp32_is_nan(a);
    assign is_nan_b = fp32_is_nan(b);

endmodule

// File: rtl/layer_2_maxpool.sv
// Streaming 2x2 / stride-2 FP32 max-pool for one channel, raster-order input.
// Define MAXPOOL_NAN_PROP_EN to force a quiet NaN out of any window containing a NaN.
module layer_2_maxpool
    import layer_2_maxpool_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int IMG_SIZE   = 208
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  valid_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    output logic                  last_out
);

    localparam int HALF = IMG_SIZE / 2;
    localparam int CW   = cnt_width(IMG_SIZE);
    localparam int LBW  = cnt_width(HALF);
    localparam logic [CW-1:0] LAST_IDX = CW'(IMG_SIZE - 1);

    generate
        if ((IMG_SIZE % 2) != 0) begin : g_bad_size
            $error("layer_2_maxpool: IMG_SIZE must be even");
        end
        if (DATA_WIDTH != FP32_WIDTH) begin : g_bad_width
            $error("layer_2_maxpool: DATA_WIDTH must be 32");
        end
    endgenerate

    logic [CW-1:0]         col;
    logic [CW-1:0]         row;
    logic [DATA_WIDTH-1:0] pair;
    logic [DATA_WIDTH-1:0] linebuf [HALF];
    logic [LBW-1:0]        lb_idx;
    logic [DATA_WIDTH-1:0] lb_rd;
    logic [DATA_WIDTH-1:0] hmax;
    logic [DATA_WIDTH-1:0] vmax;
    logic [DATA_WIDTH-1:0] pool_val;
    logic                  h_nan_a, h_nan_b, v_nan_a, v_nan_b;
    logic                  lb_wr;

    assign lb_idx = LBW'(col >> 1);
    assign lb_rd  = linebuf[lb_idx];
    assign lb_wr  = !Rst && valid_in && col[0] && !row[0];

    fp32_max u_hmax (
        .a        (pair),
        .b        (data_in),
        .max_val  (hmax),
        .is_nan_a (h_nan_a),
        .is_nan_b (h_nan_b)
    );

    fp32_max u_vmax (
        .a        (lb_rd),
        .b        (hmax),
        .max_val  (vmax),
        .is_nan_a (v_nan_a),
        .is_nan_b (v_nan_b)
    );

`ifdef MAXPOOL_NAN_PROP_EN
    // hmax alone cannot tell whether a negative NaN was in the top row, so keep a flag.
    logic lb_nan [HALF];
    logic unused_nan;

    assign unused_nan = v_nan_a ^ v_nan_b;
    assign pool_val   = (h_nan_a || h_nan_b || lb_nan[lb_idx]) ? FP32_QNAN : vmax;

    always_ff @(posedge Clk) begin
        if (lb_wr) begin
            lb_nan[lb_idx] <= h_nan_a | h_nan_b;
        end
    end
`else
    logic unused_nan;

    assign unused_nan = h_nan_a ^ h_nan_b ^ v_nan_a ^ v_nan_b;
    assign pool_val   = vmax;
`endif

    // Every entry is written on an even row before its odd-row read, so no reset is needed.
    always_ff @(posedge Clk) begin
        if (lb_wr) begin
            linebuf[lb_idx] <= hmax;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            col       <= '0;
            row       <= '0;
            pair      <= '0;
            data_out  <= '0;
            valid_out <= 1'b0;
            last_out  <= 1'b0;
        end else begin
            valid_out <= 1'b0;
            last_out  <= 1'b0;
            if (valid_in) begin
                if (col == LAST_IDX) begin
                    col <= '0;
                    row <= (row == LAST_IDX) ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end

                if (!col[0]) begin
                    pair <= data_in;
                end else if (row[0]) begin
                    data_out  <= pool_val;
                    valid_out <= 1'b1;
                    last_out  <= (row == LAST_IDX) && (col == LAST_IDX);
                end
            end
        end
    end

endmodule
